// File: rtl/fwd_pkg.sv
// Shared definitions for the forwarding/hazard unit: operand-select encoding,
// in-flight slot record and the clog2 helper used to size select fields.
package fwd_pkg;

    localparam int unsigned SEL_RF = 0;
    localparam int unsigned CNT_W  = 32;

    typedef struct packed {
        logic valid;
        logic we;
        logic load;
    } slotMeta_t;

    localparam int unsigned SLOT_META_W = $bits(slotMeta_t);

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < n) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request / hazard-response bundle between the pipeline and fwd_hazard_unit.
interface fwd_hazard_unit_if
    import fwd_pkg::*;
#(
    parameter int unsigned AW    = 5,
    parameter int unsigned DEPTH = 3
) ();

    localparam int unsigned SW = clog2(DEPTH + 1);

    logic          issue_valid;
    logic [AW-1:0] issue_rd;
    logic          issue_we;
    logic          issue_load;
    logic [AW-1:0] id_rs;
    logic [AW-1:0] id_rt;
    logic          id_rs_used;
    logic          id_rt_used;
    logic          id_branch;
    logic          flush;

    logic          stall;
    logic [SW-1:0] ex_fwd_rs_sel;
    logic [SW-1:0] ex_fwd_rt_sel;
    logic [SW-1:0] id_fwd_rs_sel;
    logic [SW-1:0] id_fwd_rt_sel;

    modport master (
        output issue_valid, issue_rd, issue_we, issue_load,
        output id_rs, id_rt, id_rs_used, id_rt_used, id_branch, flush,
        input  stall, ex_fwd_rs_sel, ex_fwd_rt_sel, id_fwd_rs_sel, id_fwd_rt_sel
    );

    modport slave (
        input  issue_valid, issue_rd, issue_we, issue_load,
        input  id_rs, id_rt, id_rs_used, id_rt_used, id_branch, flush,
        output stall, ex_fwd_rs_sel, ex_fwd_rt_sel, id_fwd_rs_sel, id_fwd_rt_sel
    );

endinterface

// File: rtl/fwd_match.sv
// Compares one ID source register against every in-flight slot and reports the
// youngest matching slot, the slot from which its result becomes forwardable, and readiness.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int unsigned AW       = 5,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 2,
    localparam int unsigned IW      = clog2(DEPTH + 1)
) (
    input  logic [AW-1:0]             src,
    input  logic                      srcUsed,
    input  slotMeta_t [DEPTH-1:0]     slotMeta,
    input  logic [DEPTH-1:0][AW-1:0]  slotRd,
    output logic                      hit_c,
    output logic [IW-1:0]             matchIdx_c,
    output logic [IW-1:0]             readyIdx_c,
    output logic                      fwdReady_c
);

    logic hitLoad;

    // Youngest writer wins: first hit scanning from slot 0 upward locks the result.
    always_comb begin
        hit_c      = 1'b0;
        matchIdx_c = '0;
        hitLoad    = 1'b0;
        if (srcUsed && (src != '0)) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!hit_c && slotMeta[i].valid && slotMeta[i].we && (slotRd[i] == src)) begin
                    hit_c      = 1'b1;
                    matchIdx_c = IW'(i);
                    hitLoad    = slotMeta[i].load;
                end
            end
        end
    end

    always_comb begin
        readyIdx_c = hitLoad ? IW'(LOAD_LAT) : IW'(1);
        fwdReady_c = hit_c && (matchIdx_c >= readyIdx_c);
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding and load-use/branch hazard detection over a shifting window of
// in-flight instructions. Optional perf counters when FWD_HAZARD_PERF_EN is defined.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned AW       = 5,
    parameter int unsigned DEPTH    = 3,
    parameter int unsigned LOAD_LAT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    fwd_hazard_unit_if.slave bus
`ifdef FWD_HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] fwd_events
`endif
);

    localparam int unsigned SW = clog2(DEPTH + 1);

    if ((DEPTH < 2) || (DEPTH > 6)) begin : gBadDepth
        $error("fwd_hazard_unit: DEPTH must be within 2..6");
    end
    if ((LOAD_LAT < 1) || (LOAD_LAT > DEPTH - 1)) begin : gBadLoadLat
        $error("fwd_hazard_unit: LOAD_LAT must be within 1..DEPTH-1");
    end

    slotMeta_t [DEPTH-1:0]    slotMeta;
    logic [DEPTH-1:0][AW-1:0] slotRd;
    logic [SW-1:0]            exRsSel;
    logic [SW-1:0]            exRtSel;

    logic          rsHit, rtHit, rsFwdReady, rtFwdReady;
    logic [SW-1:0] rsIdx, rtIdx, rsReady, rtReady;

    fwd_match #(.AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) uRsMatch (
        .src        (bus.id_rs),
        .srcUsed    (bus.id_rs_used),
        .slotMeta   (slotMeta),
        .slotRd     (slotRd),
        .hit_c      (rsHit),
        .matchIdx_c (rsIdx),
        .readyIdx_c (rsReady),
        .fwdReady_c (rsFwdReady)
    );

    fwd_match #(.AW(AW), .DEPTH(DEPTH), .LOAD_LAT(LOAD_LAT)) uRtMatch (
        .src        (bus.id_rt),
        .srcUsed    (bus.id_rt_used),
        .slotMeta   (slotMeta),
        .slotRd     (slotRd),
        .hit_c      (rtHit),
        .matchIdx_c (rtIdx),
        .readyIdx_c (rtReady),
        .fwdReady_c (rtFwdReady)
    );

    logic          rsStall, rtStall, stallInt;
    logic [SW-1:0] rsExNext, rtExNext;

    // An ID branch needs the value this cycle; an EX consumer gets one more cycle of ageing.
    always_comb begin
        rsStall  = 1'b0;
        rtStall  = 1'b0;
        rsExNext = SW'(SEL_RF);
        rtExNext = SW'(SEL_RF);
        if (rsHit) begin
            rsStall = bus.id_branch ? !rsFwdReady : ((rsIdx + SW'(1)) < rsReady);
            if (rsIdx <= SW'(DEPTH - 2)) rsExNext = rsIdx + SW'(1);
        end
        if (rtHit) begin
            rtStall = bus.id_branch ? !rtFwdReady : ((rtIdx + SW'(1)) < rtReady);
            if (rtIdx <= SW'(DEPTH - 2)) rtExNext = rtIdx + SW'(1);
        end
        stallInt = rsStall || rtStall;
    end

    // The WB slot stays live while the branch reads it, so ID may select slot DEPTH-1.
    always_comb begin
        bus.stall         = stallInt;
        bus.ex_fwd_rs_sel = exRsSel;
        bus.ex_fwd_rt_sel = exRtSel;
        bus.id_fwd_rs_sel = (bus.id_branch && rsFwdReady) ? rsIdx : SW'(SEL_RF);
        bus.id_fwd_rt_sel = (bus.id_branch && rtFwdReady) ? rtIdx : SW'(SEL_RF);
    end

    // Slot window ages one stage per cycle; flush kills the ID instruction and the one leaving EX.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slotMeta <= '0;
            slotRd   <= '0;
            exRsSel  <= SW'(SEL_RF);
            exRtSel  <= SW'(SEL_RF);
        end else begin
            for (int i = 1; i < DEPTH; i++) begin
                slotMeta[i] <= slotMeta[i-1];
                slotRd[i]   <= slotRd[i-1];
            end
            if (bus.flush) begin
                slotMeta[0] <= '0;
                slotMeta[1] <= '0;
                exRsSel     <= SW'(SEL_RF);
                exRtSel     <= SW'(SEL_RF);
            end else if (stallInt) begin
                slotMeta[0] <= '0;
            end else begin
                slotMeta[0] <= '{valid: bus.issue_valid, we: bus.issue_we, load: bus.issue_load};
                slotRd[0]   <= bus.issue_rd;
                exRsSel     <= rsExNext;
                exRtSel     <= rtExNext;
            end
        end
    end

`ifdef FWD_HAZARD_PERF_EN
    // Saturating counters of stalled cycles and of advances that pick a forwarded operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
            fwd_events   <= '0;
        end else begin
            if (stallInt && (stall_cycles != '1)) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (!bus.flush && !stallInt && ((rsExNext != SW'(SEL_RF)) || (rtExNext != SW'(SEL_RF)))
                && (fwd_events != '1)) begin
                fwd_events <= fwd_events + CNT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Bench for fwd_hazard_unit: two configurations (DEPTH=3/LOAD_LAT=2, DEPTH=4/LOAD_LAT=3)
// share one stimulus stream and are checked against an instruction-history reference model.
module tb_fwd_hazard_unit;

    typedef struct packed {
        bit       valid;
        bit [4:0] rd;
        bit       we;
        bit       load;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic issueValid, issueWe, issueLoad, idRsUsed, idRtUsed, idBranch, flush;
    logic [4:0] issueRd, idRs, idRt;

    int checks = 0;
    int errors = 0;

    // hist[c][k] = instruction that entered EX k cycles ago (bubbles included) for config c.
    rec_t hist[2][8];
    int   expEx[2][2];
    int   stallCnt[2];
    int   fwdCnt[2];
    int   depthOf[2] = '{3, 4};
    int   latOf[2]   = '{2, 3};
    logic [31:0] obsStall[2], obsIdRs[2], obsIdRt[2];

    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.AW(5), .DEPTH(3)) busA ();
    fwd_hazard_unit_if #(.AW(5), .DEPTH(4)) busB ();

    assign busA.issue_valid = issueValid;  assign busB.issue_valid = issueValid;
    assign busA.issue_rd    = issueRd;     assign busB.issue_rd    = issueRd;
    assign busA.issue_we    = issueWe;     assign busB.issue_we    = issueWe;
    assign busA.issue_load  = issueLoad;   assign busB.issue_load  = issueLoad;
    assign busA.id_rs       = idRs;        assign busB.id_rs       = idRs;
    assign busA.id_rt       = idRt;        assign busB.id_rt       = idRt;
    assign busA.id_rs_used  = idRsUsed;    assign busB.id_rs_used  = idRsUsed;
    assign busA.id_rt_used  = idRtUsed;    assign busB.id_rt_used  = idRtUsed;
    assign busA.id_branch   = idBranch;    assign busB.id_branch   = idBranch;
    assign busA.flush       = flush;       assign busB.flush       = flush;

`ifdef FWD_HAZARD_PERF_EN
    logic [31:0] stallCyclesA, fwdEventsA, stallCyclesB, fwdEventsB;
`endif

    fwd_hazard_unit #(.AW(5), .DEPTH(3), .LOAD_LAT(2)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA)
`ifdef FWD_HAZARD_PERF_EN
        ,
        .stall_cycles (stallCyclesA),
        .fwd_events   (fwdEventsA)
`endif
    );

    fwd_hazard_unit #(.AW(5), .DEPTH(4), .LOAD_LAT(3)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB)
`ifdef FWD_HAZARD_PERF_EN
        ,
        .stall_cycles (stallCyclesB),
        .fwd_events   (fwdEventsB)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Youngest in-flight writer of src, or -1.
    function automatic int findK(input int c, input logic [4:0] src, input logic used);
        if (!used || src == 5'd0) return -1;
        for (int k = 0; k < depthOf[c]; k++)
            if (hist[c][k].valid && hist[c][k].we && hist[c][k].rd == src) return k;
        return -1;
    endfunction

    function automatic int readyOf(input int c, input int k);
        return hist[c][k].load ? latOf[c] : 1;
    endfunction

    function automatic bit srcStall(input int c, input logic [4:0] src, input logic used,
                                    input logic branch);
        int k = findK(c, src, used);
        if (k < 0) return 1'b0;
        return branch ? (k < readyOf(c, k)) : (k + 1 < readyOf(c, k));
    endfunction

    function automatic int exSelOf(input int c, input logic [4:0] src, input logic used);
        int k = findK(c, src, used);
        return (k >= 0 && k <= depthOf[c] - 2) ? k + 1 : 0;
    endfunction

    function automatic int idSelOf(input int c, input logic [4:0] src, input logic used,
                                   input logic branch);
        int k = findK(c, src, used);
        if (!branch || k < 0) return 0;
        return (k >= readyOf(c, k)) ? k : 0;
    endfunction

    task automatic clearModel();
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < 8; k++) hist[c][k] = '0;
            expEx[c][0] = 0;
            expEx[c][1] = 0;
            stallCnt[c] = 0;
            fwdCnt[c]   = 0;
        end
    endtask

    task automatic setIssue(input bit v, input logic [4:0] rd, input bit we, input bit ld);
        issueValid = v; issueRd = rd; issueWe = we; issueLoad = ld;
    endtask

    task automatic setSrc(input logic [4:0] rs, input bit rsU, input logic [4:0] rt, input bit rtU,
                          input bit br);
        idRs = rs; idRsUsed = rsU; idRt = rt; idRtUsed = rtU; idBranch = br;
    endtask

    // One clock: check combinational outputs, advance the model, check registered selects.
    task automatic step(input string tag);
        bit st[2];
        int nEx[2][2];
        #1;
        obsStall[0] = busA.stall;         obsStall[1] = busB.stall;
        obsIdRs[0]  = busA.id_fwd_rs_sel; obsIdRs[1]  = busB.id_fwd_rs_sel;
        obsIdRt[0]  = busA.id_fwd_rt_sel; obsIdRt[1]  = busB.id_fwd_rt_sel;
        for (int c = 0; c < 2; c++) begin
            st[c] = srcStall(c, idRs, idRsUsed, idBranch) || srcStall(c, idRt, idRtUsed, idBranch);
            nEx[c][0] = exSelOf(c, idRs, idRsUsed);
            nEx[c][1] = exSelOf(c, idRt, idRtUsed);
            chk($sformatf("%s stall cfg%0d", tag, c), obsStall[c], 32'(st[c]));
            chk($sformatf("%s idRs cfg%0d", tag, c), obsIdRs[c], idSelOf(c, idRs, idRsUsed, idBranch));
            chk($sformatf("%s idRt cfg%0d", tag, c), obsIdRt[c], idSelOf(c, idRt, idRtUsed, idBranch));
        end
        @(posedge clk);
        for (int c = 0; c < 2; c++) begin
            if (st[c]) stallCnt[c]++;
            if (!flush && !st[c] && (nEx[c][0] != 0 || nEx[c][1] != 0)) fwdCnt[c]++;
            for (int k = 7; k > 0; k--) hist[c][k] = hist[c][k-1];
            hist[c][0] = '0;
            if (flush) begin
                hist[c][1]  = '0;
                expEx[c][0] = 0;
                expEx[c][1] = 0;
            end else if (!st[c]) begin
                hist[c][0]  = '{valid: issueValid, rd: issueRd, we: issueWe, load: issueLoad};
                expEx[c][0] = nEx[c][0];
                expEx[c][1] = nEx[c][1];
            end
        end
        #1;
        chk($sformatf("%s exRs cfg0", tag), busA.ex_fwd_rs_sel, expEx[0][0]);
        chk($sformatf("%s exRt cfg0", tag), busA.ex_fwd_rt_sel, expEx[0][1]);
        chk($sformatf("%s exRs cfg1", tag), busB.ex_fwd_rs_sel, expEx[1][0]);
        chk($sformatf("%s exRt cfg1", tag), busB.ex_fwd_rt_sel, expEx[1][1]);
        @(negedge clk);
    endtask

    task automatic drain();
        setIssue(0, 5'd0, 0, 0);
        setSrc(5'd0, 0, 5'd0, 0, 0);
        flush = 1'b0;
        repeat (5) step("drain");
    endtask

    // Asynchronous reset pulse between clock edges; outputs must clear without a clock.
    task automatic midReset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        chk({tag, " stallA"}, busA.stall, 0);
        chk({tag, " stallB"}, busB.stall, 0);
        chk({tag, " exRsA"}, busA.ex_fwd_rs_sel, 0);
        chk({tag, " exRtB"}, busB.ex_fwd_rt_sel, 0);
        chk({tag, " idRsA"}, busA.id_fwd_rs_sel, 0);
        clearModel();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        setIssue(0, 5'd0, 0, 0);
        setSrc(5'd0, 0, 5'd0, 0, 0);
        clearModel();
        #1;
        chk("reset stallA", busA.stall, 0);
        chk("reset exRsA", busA.ex_fwd_rs_sel, 0);
        chk("reset exRtB", busB.ex_fwd_rt_sel, 0);
        chk("reset idRtB", busB.id_fwd_rt_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ALU result consumed by the next instruction
        drain();
        setIssue(1, 5'd27, 1, 0); step("alu27");
        setIssue(1, 5'd0, 0, 0);  setSrc(5'd27, 1, 5'd0, 0, 0); step("use27");
        chk("use27 stallA", obsStall[0], 0);
        chk("use27 exRsA", busA.ex_fwd_rs_sel, 1);
        chk("use27 exRsB", busB.ex_fwd_rs_sel, 1);

        // Load-use
        drain();
        setIssue(1, 5'd5, 1, 1); step("ld5");
        setIssue(1, 5'd0, 0, 0); setSrc(5'd5, 1, 5'd0, 0, 0);
        step("use5 c1");
        chk("use5 c1 stallA", obsStall[0], 1);
        chk("use5 c1 stallB", obsStall[1], 1);
        step("use5 c2");
        chk("use5 c2 stallA", obsStall[0], 0);
        chk("use5 c2 stallB", obsStall[1], 1);
        chk("use5 exRsA", busA.ex_fwd_rs_sel, 2);
        step("use5 c3");
        chk("use5 c3 stallB", obsStall[1], 0);
        chk("use5 exRsB", busB.ex_fwd_rs_sel, 3);

        // Branch after ALU producer
        drain();
        setIssue(1, 5'd30, 1, 0); step("alu30");
        setIssue(1, 5'd0, 0, 0);  setSrc(5'd30, 1, 5'd0, 0, 1);
        step("br30 c1");
        chk("br30 c1 stallA", obsStall[0], 1);
        step("br30 c2");
        chk("br30 c2 stallA", obsStall[0], 0);
        chk("br30 idRsA", obsIdRs[0], 1);
        chk("br30 idRsB", obsIdRs[1], 1);

        // Branch after load producer
        drain();
        setIssue(1, 5'd24, 1, 1); step("ld24");
        setIssue(1, 5'd0, 0, 0);  setSrc(5'd0, 0, 5'd24, 1, 1);
        step("br24 c1");
        step("br24 c2");
        chk("br24 c2 stallA", obsStall[0], 1);
        step("br24 c3");
        chk("br24 c3 stallA", obsStall[0], 0);
        chk("br24 idRtA", obsIdRt[0], 2);
        chk("br24 c3 stallB", obsStall[1], 1);
        step("br24 c4");
        chk("br24 c4 stallB", obsStall[1], 0);
        chk("br24 idRtB", obsIdRt[1], 3);

        // r0 writer and non-writing r27 never create a hazard
        drain();
        setIssue(1, 5'd0, 1, 0); step("w0");
        setIssue(1, 5'd0, 0, 0); setSrc(5'd0, 1, 5'd0, 1, 0); step("use0");
        chk("use0 stallA", obsStall[0], 0);
        chk("use0 exRsA", busA.ex_fwd_rs_sel, 0);
        setIssue(1, 5'd27, 0, 0); setSrc(5'd0, 0, 5'd0, 0, 0); step("nowe27");
        setIssue(1, 5'd0, 0, 0);  setSrc(5'd27, 1, 5'd27, 1, 1); step("usenowe");
        chk("usenowe stallA", obsStall[0], 0);
        chk("usenowe idRsA", obsIdRs[0], 0);
        chk("usenowe exRtA", busA.ex_fwd_rt_sel, 0);

        // Flush while the load-use stall is active
        drain();
        setIssue(1, 5'd5, 1, 1); step("fl ld5");
        setIssue(1, 5'd0, 0, 0); setSrc(5'd5, 1, 5'd0, 0, 0);
        flush = 1'b1;
        step("fl c1");
        chk("fl c1 stallA", obsStall[0], 1);
        chk("fl exRsA", busA.ex_fwd_rs_sel, 0);
        flush = 1'b0;
        step("fl c2");
        chk("fl c2 stallA", obsStall[0], 0);
        chk("fl c2 stallB", obsStall[1], 0);

        // Reset while stalled
        drain();
        setIssue(1, 5'd5, 1, 1); step("rs ld5");
        setIssue(1, 5'd0, 0, 0); setSrc(5'd5, 1, 5'd0, 0, 0);
        #1;
        chk("rs pre stallA", busA.stall, 1);
        midReset("rs mid");
        step("rs post");
        chk("rs post stallA", obsStall[0], 0);
        chk("rs post stallB", obsStall[1], 0);

        // Random traffic over a small register set to provoke frequent hazards
        for (int n = 0; n < 400; n++) begin
            setIssue(1'($urandom_range(3) != 0), 5'($urandom_range(7)),
                     1'($urandom_range(1)), 1'($urandom_range(2) == 0));
            setSrc(5'($urandom_range(7)), 1'($urandom_range(3) != 0),
                   5'($urandom_range(7)), 1'($urandom_range(3) != 0),
                   1'($urandom_range(3) == 0));
            flush = 1'($urandom_range(15) == 0);
            step("rand");
            if (n == 200) midReset("rand rst");
        end
        flush = 1'b0;

`ifdef FWD_HAZARD_PERF_EN
        chk("stall_cycles cfg0", stallCyclesA, stallCnt[0]);
        chk("stall_cycles cfg1", stallCyclesB, stallCnt[1]);
        chk("fwd_events cfg0", fwdEventsA, fwdCnt[0]);
        chk("fwd_events cfg1", fwdEventsB, fwdCnt[1]);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
